alu_arb_ctrl: RTL and testbench
===============================

ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 SHALL have parameter: FIRST_PRIO, 0, requester index holding priority after reset (0 or 1).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_valid  input  2  per-requester operation request, bit i = requester i.
REQ-005 SHALL have port: req_ready  output  2  per-requester accept; a transfer occurs when valid and ready are both 1 on an edge.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  4 each  operands A/B per requester.
REQ-007 SHALL have ports: req0_c, req1_c  input  2 each  shift amount per requester.
REQ-008 SHALL have ports: req0_op, req1_op  input  2 each  opcode: 00 arithmetic shift right A by C, 01 logical shift right A by C, 10 A-B, 11 A+B.
REQ-009 SHALL have port: resp_valid  output  2  per-requester result valid.
REQ-010 SHALL have port: resp_ready  input  2  per-requester result accept.
REQ-011 SHALL have port: resp_data  output  4  result shared by both requesters, qualified by resp_valid.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
- IDLE: entered after reset.
- EXEC: lasts exactly one cycle.
- RESP: held until the response is accepted.
REQ-014 In IDLE with any req_valid bit set, SHALL grant one requester, assert req_ready for that bit combinationally in the same cycle, latch its a/b/c/op and grant index, and move to EXEC.
REQ-015 When only one requester is valid, SHALL grant it regardless of the priority pointer.
REQ-016 When both are valid, SHALL grant the requester named by the round-robin pointer.
REQ-017 SHALL keep req_ready at 00 in EXEC and RESP; requests arriving then stay pending and are not dropped.
REQ-018 In EXEC, SHALL drive the latched operands into the shared ALU, register the 4-bit result into resp_data, and move to RESP.
REQ-019 In RESP, SHALL assert resp_valid only on the granted bit and hold resp_data stable until the matching resp_ready bit is 1.
REQ-020 On resp_ready for the granted bit in RESP, SHALL return to IDLE and set the pointer to the other requester; resp_ready on the non-granted bit is ignored.
REQ-021 Latency SHALL be: accept on edge N, resp_valid high from after edge N+1; with resp_ready held high, the next accept is possible no earlier than edge N+3.
REQ-022 Arithmetic SHALL be modulo 16 with no carry or borrow output.
REQ-023 Opcode 00 SHALL replicate A[3]; opcode 01 SHALL zero-fill.
REQ-024 resp_data SHALL hold its last value in IDLE.

Reset
REQ-025 While rst_n=0, SHALL force: FSM to IDLE, req_ready=00, resp_valid=00, resp_data=0000, busy=0, pointer=FIRST_PRIO, latched operands=0.
REQ-026 Reset asserted during EXEC or RESP SHALL discard the in-flight operation with no response delivered.
REQ-027 Reset deassertion SHALL take effect on the first clk edge after rst_n rises.

Structure
REQ-028 Opcode encodings and FSM state encodings SHALL live in a shared package, alu_pkg.
REQ-029 SHALL contain exactly one sub-module: the team's existing combinational 4-bit ALU, instantiated once as u_alu, with no arithmetic duplicated in this block.
REQ-030 resp_data, the pointer, the FSM state and the latched operands SHALL be flops; req_ready and resp_valid SHALL be decoded from state and grant.

Verification
REQ-031 Bench SHALL cover: req0 op=11 a=7 b=9 -> resp_valid=01, resp_data=0000 one cycle after accept.
REQ-032 Bench SHALL cover: req1 op=10 a=3 b=5 -> resp_valid=10, resp_data=1110.
REQ-033 Bench SHALL cover: req0 op=00 a=1000 c=2 -> 1110; then op=01 a=1000 c=2 -> 0010.
REQ-034 Bench SHALL cover: both valid continuously, FIRST_PRIO=0, resp_ready=11 -> grants alternate 0,1,0,1, one accept every 3 cycles.
REQ-035 Bench SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_data and resp_valid stable, req_ready=00 throughout.
REQ-036 Bench SHALL cover: rst_n pulled low in RESP -> outputs zero immediately (async), no response delivered, and the next grant after release goes to FIRST_PRIO.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: data widths,
// opcode and FSM encodings, and the latched operand bundle.
package alu_pkg;

    localparam int DATA_W  = 4;
    localparam int SHAMT_W = 2;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        OP_ASR = 2'b00,   // arithmetic shift right A by C
        OP_LSR = 2'b01,   // logical shift right A by C
        OP_SUB = 2'b10,   // A - B, modulo 16
        OP_ADD = 2'b11    // A + B, modulo 16
    } aluOp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } ctrlState_t;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [SHAMT_W-1:0] c;
        aluOp_t             op;
    } aluOperands_t;

    // One-hot requester mask for a requester index.
    function automatic logic [NUM_REQ-1:0] oneHot(input logic idx);
        logic [NUM_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/alu_arb_ctrl_alu.sv
// Combinational 4-bit ALU: shifts by C, subtract and add, all modulo 16.
module alu_arb_ctrl_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0]  a,
    input  logic [DATA_W-1:0]  b,
    input  logic [SHAMT_W-1:0] c,
    input  aluOp_t             op,
    output logic [DATA_W-1:0]  y
);

    // Select the result for the current opcode; carries and borrows drop off.
    always_comb begin
        y = '0;
        case (op)
            OP_ASR:  y = DATA_W'($signed(a) >>> c);
            OP_LSR:  y = a >> c;
            OP_SUB:  y = a - b;
            OP_ADD:  y = a + b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Two-requester round-robin arbiter in front of a shared 4-bit ALU.
// One operation is in flight at a time: IDLE accepts, EXEC computes for
// one cycle, RESP holds the result until the granted requester takes it.
module alu_arb_ctrl
    import alu_pkg::*;
#(
    parameter int FIRST_PRIO = 0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [DATA_W-1:0]   req0_a,
    input  logic [DATA_W-1:0]   req0_b,
    input  logic [SHAMT_W-1:0]  req0_c,
    input  logic [1:0]          req0_op,
    input  logic [DATA_W-1:0]   req1_a,
    input  logic [DATA_W-1:0]   req1_b,
    input  logic [SHAMT_W-1:0]  req1_c,
    input  logic [1:0]          req1_op,
    output logic [NUM_REQ-1:0]  resp_valid,
    input  logic [NUM_REQ-1:0]  resp_ready,
    output logic [DATA_W-1:0]   resp_data,
    output logic                busy
);

    localparam logic FIRST_PRIO_BIT = 1'(FIRST_PRIO);

    ctrlState_t        stateReg, stateNext;
    logic              grantReg;
    logic              ptrReg;
    aluOperands_t      opsReg;
    logic [DATA_W-1:0] respDataReg;

    logic              grantSel;
    aluOperands_t      opsSel;
    logic [DATA_W-1:0] aluResult;
    logic              anyValid;
    logic              acceptFire;
    logic              respFire;

    assign anyValid   = |req_valid;
    assign acceptFire = (stateReg == ST_IDLE) && anyValid;
    assign respFire   = (stateReg == ST_RESP) && resp_ready[grantReg];

    // A lone requester wins outright; a tie goes to the round-robin pointer.
    always_comb begin
        grantSel = ptrReg;
        if (req_valid == 2'b01) begin
            grantSel = 1'b0;
        end else if (req_valid == 2'b10) begin
            grantSel = 1'b1;
        end
    end

    // Route the winning requester's operands toward the operand latch.
    always_comb begin
        opsSel = '0;
        if (grantSel) begin
            opsSel.a  = req1_a;
            opsSel.b  = req1_b;
            opsSel.c  = req1_c;
            opsSel.op = aluOp_t'(req1_op);
        end else begin
            opsSel.a  = req0_a;
            opsSel.b  = req0_b;
            opsSel.c  = req0_c;
            opsSel.op = aluOp_t'(req0_op);
        end
    end

    alu_arb_ctrl_alu u_alu (
        .a  (opsReg.a),
        .b  (opsReg.b),
        .c  (opsReg.c),
        .op (opsReg.op),
        .y  (aluResult)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // FSM next-state: accept, compute for one cycle, wait for the taker.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            ST_IDLE: if (anyValid) stateNext = ST_EXEC;
            ST_EXEC: stateNext = ST_RESP;
            ST_RESP: if (respFire) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes are decoded from state and grant only.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        busy       = (stateReg != ST_IDLE);
        case (stateReg)
            ST_IDLE: if (rst_n && anyValid) req_ready = oneHot(grantSel);
            ST_RESP: resp_valid = oneHot(grantReg);
            default: ;
        endcase
    end

    // Operand/grant latch, result register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grantReg    <= 1'b0;
            ptrReg      <= FIRST_PRIO_BIT;
            opsReg      <= '0;
            respDataReg <= '0;
        end else begin
            if (acceptFire) begin
                opsReg   <= opsSel;
                grantReg <= grantSel;
            end
            if (stateReg == ST_EXEC) begin
                respDataReg <= aluResult;
            end
            if (respFire) begin
                ptrReg <= ~grantReg;
            end
        end
    end

    assign resp_data = respDataReg;

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Self-checking bench for alu_arb_ctrl: directed scenarios followed by a
// randomized run, all compared against a transaction-level reference model.
module tb_alu_arb_ctrl;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] reqValid = 2'b00;
    logic [1:0] respReady = 2'b00;
    logic [3:0] aIn  [2];
    logic [3:0] bIn  [2];
    logic [1:0] cIn  [2];
    logic [1:0] opIn [2];
    logic [1:0] reqReady;
    logic [1:0] respValid;
    logic [3:0] respData;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: an in-flight operation ages one step per edge;
    // age 1 is the compute cycle, age 2+ means the result is offered.
    bit mInFlight;
    int mAge;
    int mGrant;
    int mPtr;
    int mResult;
    int mLast;
    int acceptedIdx;
    int obsGrant;

    alu_arb_ctrl #(.FIRST_PRIO(0)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req0_a     (aIn[0]),
        .req0_b     (bIn[0]),
        .req0_c     (cIn[0]),
        .req0_op    (opIn[0]),
        .req1_a     (aIn[1]),
        .req1_b     (bIn[1]),
        .req1_c     (cIn[1]),
        .req1_op    (opIn[1]),
        .resp_valid (respValid),
        .resp_ready (respReady),
        .resp_data  (respData),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Opcode semantics from plain integer arithmetic.
    function automatic int refAlu(input int op, input int a, input int b, input int c);
        int sa;
        int p;
        int q;
        p = 1 << c;
        case (op)
            0: begin
                sa = (a >= 8) ? a - 16 : a;
                q  = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);  // floor division
                return (q + 16) % 16;
            end
            1:       return a / p;
            2:       return (a - b + 16) % 16;
            default: return (a + b) % 16;
        endcase
    endfunction

    function automatic int pick(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return mPtr;
    endfunction

    task automatic modelReset();
        mInFlight = 0;
        mAge      = 0;
        mGrant    = 0;
        mPtr      = 0;
        mResult   = 0;
        mLast     = 0;
    endtask

    task automatic setOps(input int idx, input int op, input int a, input int b, input int c);
        opIn[idx] = 2'(op);
        aIn[idx]  = 4'(a);
        bIn[idx]  = 4'(b);
        cIn[idx]  = 2'(c);
    endtask

    task automatic randOps(input int idx);
        setOps(idx, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    endtask

    // One clock cycle, entered at a negedge with inputs already driven:
    // compare all outputs to the model, then advance the model on the edge.
    task automatic step();
        int expReady;
        int expValid;
        int g;
        #1;
        expReady = (rstN && !mInFlight && reqValid != 2'b00) ? (1 << pick(reqValid)) : 0;
        expValid = (rstN && mInFlight && mAge >= 2) ? (1 << mGrant) : 0;
        chk("req_ready",  32'(reqReady),  32'(expReady));
        chk("resp_valid", 32'(respValid), 32'(expValid));
        chk("resp_data",  32'(respData),  32'(rstN ? mLast : 0));
        chk("busy",       32'(busy),      32'(rstN && mInFlight));
        obsGrant = (reqReady == 2'b01) ? 0 : (reqReady == 2'b10) ? 1 : -1;
        @(posedge clk);
        cyc++;
        acceptedIdx = -1;
        if (!rstN) begin
            modelReset();
        end else if (!mInFlight) begin
            if (reqValid != 2'b00) begin
                g           = pick(reqValid);
                mInFlight   = 1;
                mAge        = 1;
                mGrant      = g;
                mResult     = refAlu(int'(opIn[g]), int'(aIn[g]), int'(bIn[g]), int'(cIn[g]));
                acceptedIdx = g;
            end
        end else if (mAge == 1) begin
            mAge  = 2;
            mLast = mResult;
        end else if (respReady[mGrant]) begin
            mInFlight = 0;
            mPtr      = 1 - mGrant;
        end
        @(negedge clk);
    endtask

    // Single-requester operation with a known result one cycle after accept.
    task automatic directedOp(input int idx, input int op, input int a, input int b,
                              input int c, input int expData);
        respReady = 2'b00;
        setOps(idx, op, a, b, c);
        reqValid = (idx != 0) ? 2'b10 : 2'b01;
        step();
        chk("dir_accept", 32'(acceptedIdx), 32'(idx));
        reqValid = 2'b00;
        step();
        #1;
        chk("dir_rvalid", 32'(respValid), 32'(1 << idx));
        chk("dir_data",   32'(respData),  32'(expData));
        respReady = 2'b11;
        step();
        respReady = 2'b00;
    endtask

    task automatic holdReset(input int cycles);
        rstN = 1'b0;
        modelReset();
        for (int i = 0; i < cycles; i++) step();
        rstN = 1'b1;
    endtask

    int grants[$];
    int grantCyc[$];
    bit pending[2];

    initial begin
        for (int i = 0; i < 2; i++) setOps(i, 0, 0, 0, 0);
        rstN = 1'b0;
        modelReset();
        @(negedge clk);

        // Reset: requests present but nothing may be granted.
        reqValid = 2'b11;
        step();
        step();
        reqValid = 2'b00;
        rstN = 1'b1;
        step();

        // Known-answer operations on each requester.
        directedOp(0, 3, 7, 9, 0, 4'b0000);
        directedOp(1, 2, 3, 5, 0, 4'b1110);
        directedOp(0, 0, 8, 0, 2, 4'b1110);
        directedOp(0, 1, 8, 0, 2, 4'b0010);

        // Both requesters valid continuously from a fresh reset.
        holdReset(2);
        reqValid  = 2'b11;
        respReady = 2'b11;
        for (int i = 0; i < 13; i++) begin
            randOps(0);
            randOps(1);
            step();
            if (obsGrant >= 0) begin
                grants.push_back(obsGrant);
                grantCyc.push_back(cyc);
            end
        end
        chk("rr_count", 32'(grants.size() >= 4), 32'd1);
        if (grants.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("rr_order", 32'(grants[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) chk("rr_spacing", 32'(grantCyc[i] - grantCyc[i-1]), 32'd3);
        end
        reqValid = 2'b00;
        step();
        step();
        step();

        // Stalled response: other requester waits, wrong-bit ready ignored.
        respReady = 2'b00;
        setOps(0, 3, 3, 4, 0);
        reqValid = 2'b01;
        step();
        setOps(1, 2, 9, 2, 0);
        reqValid  = 2'b10;
        respReady = 2'b10;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_data",  32'(respData),  32'd7);
            chk("stall_valid", 32'(respValid), 32'b01);
            chk("stall_ready", 32'(reqReady),  32'b00);
            step();
        end
        respReady = 2'b01;
        step();
        respReady = 2'b11;
        step();
        chk("stall_then_req1", 32'(obsGrant), 32'd1);
        reqValid = 2'b00;
        step();
        step();
        respReady = 2'b00;

        // Reset while a response is pending.
        setOps(1, 3, 5, 6, 0);
        reqValid = 2'b10;
        step();
        reqValid = 2'b00;
        step();
        #2;
        rstN = 1'b0;
        modelReset();
        #1;
        chk("arst_rvalid", 32'(respValid), 32'd0);
        chk("arst_data",   32'(respData),  32'd0);
        chk("arst_busy",   32'(busy),      32'd0);
        chk("arst_ready",  32'(reqReady),  32'd0);
        @(negedge clk);
        reqValid  = 2'b11;
        respReady = 2'b11;
        step();
        step();
        rstN = 1'b1;
        step();
        chk("post_rst_grant", 32'(obsGrant), 32'd0);
        reqValid = 2'b00;
        step();
        step();

        // Randomized traffic: requests stay pending until accepted.
        pending[0] = 0;
        pending[1] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1;
                    randOps(i);
                end
            end
            reqValid  = {pending[1], pending[0]};
            respReady = 2'($urandom_range(0, 3));
            step();
            if (acceptedIdx >= 0) pending[acceptedIdx] = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
